// File: rtl/mxint_pkg.sv
// Shared MxInt helpers: output mantissa sizing and exponent-difference shift widths.
// Reused by the replay buffer, accumulator and cast blocks.
package mxint_pkg;

  // Summing 'depth' equal-exponent beats needs clog2(depth) guard bits.
  function automatic int mxintOutWidth(input int inWidth, input int depth);
    return inWidth + $clog2(depth);
  endfunction

  // |e_a - e_b| of two signed expWidth exponents fits in expWidth+1 unsigned bits.
  function automatic int mxintShiftWidth(input int expWidth);
    return expWidth + 1;
  endfunction

  // Any shift of at least the operand width collapses to the sign fill (0 or -1).
  function automatic bit mxintShiftSaturates(input longint unsigned shift, input int width);
    return shift >= longint'(width);
  endfunction

endpackage

// File: rtl/mxint_align_shift.sv
// Combinational arithmetic right shift used to align a mantissa to a larger exponent.
// Truncates toward -inf; shifts >= WIDTH return the pure sign fill.
module mxint_align_shift
  import mxint_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SHIFT_WIDTH = 9
) (
  input  logic [WIDTH-1:0]       data_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  output logic [WIDTH-1:0]       data_o
);

  always_comb begin
    if (mxintShiftSaturates(64'(shift_i), WIDTH)) begin
      data_o = {WIDTH{data_i[WIDTH-1]}};
    end else begin
      data_o = $signed(data_i) >>> shift_i;
    end
  end

endmodule

// File: rtl/mxint_accumulator.sv
// Folds ACC_DEPTH consecutive MxInt beats into one widened MxInt block by
// aligning each beat to the larger shared exponent and summing lane-wise.
module mxint_accumulator
  import mxint_pkg::*;
#(
  parameter  int DATA_IN_0_PRECISION_0  = 8,
  parameter  int DATA_IN_0_PRECISION_1  = 8,
  parameter  int IN_NUM                 = -1,
  parameter  int ACC_DEPTH              = -1,
  localparam int DATA_OUT_0_PRECISION_0 = mxintOutWidth(DATA_IN_0_PRECISION_0, ACC_DEPTH)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [IN_NUM-1:0][DATA_IN_0_PRECISION_0-1:0]   mdata_in,
  input  logic [DATA_IN_0_PRECISION_1-1:0]               edata_in,
  input  logic                                           data_in_valid,
  output logic                                           data_in_ready,
  output logic [IN_NUM-1:0][DATA_OUT_0_PRECISION_0-1:0]  mdata_out,
  output logic [DATA_IN_0_PRECISION_1-1:0]               edata_out,
  output logic                                           data_out_valid,
  input  logic                                           data_out_ready
);

  localparam int IW = DATA_IN_0_PRECISION_0;
  localparam int OW = DATA_OUT_0_PRECISION_0;
  localparam int EW = DATA_IN_0_PRECISION_1;
  localparam int SW = mxintShiftWidth(EW);
  localparam int CW = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

  if (IN_NUM < 1 || ACC_DEPTH < 1) begin : gBadParam
    $fatal(1, "mxint_accumulator: IN_NUM and ACC_DEPTH must both be >= 1");
  end

  logic [CW-1:0]              cnt_q, cnt_d;
  logic [IN_NUM-1:0][OW-1:0]  acc_q, acc_d;
  logic [EW-1:0]              accE_q, accE_d;
  logic [IN_NUM-1:0][OW-1:0]  mOut_q, mOut_d;
  logic [EW-1:0]              eOut_q, eOut_d;
  logic                       valid_q, valid_d;

  logic                       accept, firstBeat, lastBeat, eGreater;
  logic signed [EW:0]         eDiff;
  logic [SW-1:0]              shiftAmt;
  logic [IN_NUM-1:0][OW-1:0]  mExt, shiftIn, shiftOut, sum;

  assign data_in_ready = !valid_q || data_out_ready;
  assign accept        = data_in_valid && data_in_ready;
  assign firstBeat     = (cnt_q == '0);
  assign lastBeat      = (cnt_q == CW'(ACC_DEPTH - 1));

  assign eDiff    = $signed({edata_in[EW-1], edata_in}) - $signed({accE_q[EW-1], accE_q});
  assign eGreater = !eDiff[EW] && (eDiff != '0);
  assign shiftAmt = eDiff[EW] ? -eDiff : eDiff;

  // Only the operand with the smaller exponent is shifted, so one shifter per lane suffices.
  for (genvar g = 0; g < IN_NUM; g++) begin : gLane
    logic signed [IW-1:0] mIn;
    assign mIn        = mdata_in[g];
    assign mExt[g]    = OW'(mIn);
    assign shiftIn[g] = eGreater ? acc_q[g] : mExt[g];

    mxint_align_shift #(
      .WIDTH       (OW),
      .SHIFT_WIDTH (SW)
    ) u_alignShift (
      .data_i  (shiftIn[g]),
      .shift_i (shiftAmt),
      .data_o  (shiftOut[g])
    );

    assign sum[g] = eGreater ? (shiftOut[g] + mExt[g]) : (acc_q[g] + shiftOut[g]);
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    accE_d  = accE_q;
    mOut_d  = mOut_q;
    eOut_d  = eOut_q;
    valid_d = valid_q;
    if (valid_q && data_out_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (firstBeat) begin
        acc_d  = mExt;
        accE_d = edata_in;
      end else begin
        acc_d  = sum;
        accE_d = eGreater ? edata_in : accE_q;
      end
      // A completing block re-asserts valid even if the old result retires this cycle.
      if (lastBeat) begin
        cnt_d   = '0;
        mOut_d  = acc_d;
        eOut_d  = accE_d;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      accE_q  <= '0;
      mOut_q  <= '0;
      eOut_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      accE_q  <= accE_d;
      mOut_q  <= mOut_d;
      eOut_q  <= eOut_d;
      valid_q <= valid_d;
    end
  end

  assign mdata_out      = mOut_q;
  assign edata_out      = eOut_q;
  assign data_out_valid = valid_q;

endmodule

// File: tb/tb_mxint_accumulator.sv
// Scoreboard bench for mxint_accumulator: instance A (ACC_DEPTH=4) and B (ACC_DEPTH=2),
// both IN_NUM=2 with 8-bit mantissas and exponents.
module tb_mxint_accumulator;

  typedef struct {
    int m0;
    int m1;
    int e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][7:0] mInA, mInB;
  logic [7:0]      eInA, eInB;
  logic            inValidA, inValidB, inReadyA, inReadyB;
  logic [1:0][9:0] mOutA;
  logic [1:0][8:0] mOutB;
  logic [7:0]      eOutA, eOutB;
  logic            outValidA, outValidB, outReadyA, outReadyB;

  exp_t expA[$];
  exp_t expB[$];
  exp_t popA, popB;
  int   checks = 0;
  int   errors = 0;

  mxint_accumulator #(
    .DATA_IN_0_PRECISION_0 (8),
    .DATA_IN_0_PRECISION_1 (8),
    .IN_NUM                (2),
    .ACC_DEPTH             (4)
  ) dutA (
    .clk            (clk),
    .rst            (rst),
    .mdata_in       (mInA),
    .edata_in       (eInA),
    .data_in_valid  (inValidA),
    .data_in_ready  (inReadyA),
    .mdata_out      (mOutA),
    .edata_out      (eOutA),
    .data_out_valid (outValidA),
    .data_out_ready (outReadyA)
  );

  mxint_accumulator #(
    .DATA_IN_0_PRECISION_0 (8),
    .DATA_IN_0_PRECISION_1 (8),
    .IN_NUM                (2),
    .ACC_DEPTH             (2)
  ) dutB (
    .clk            (clk),
    .rst            (rst),
    .mdata_in       (mInB),
    .edata_in       (eInB),
    .data_in_valid  (inValidB),
    .data_in_ready  (inReadyB),
    .mdata_out      (mOutB),
    .edata_out      (eOutB),
    .data_out_valid (outValidB),
    .data_out_ready (outReadyB)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input int sel, input int m0, input int m1, input int e);
    exp_t x;
    x.m0 = m0;
    x.m1 = m1;
    x.e  = e;
    if (sel == 0) expA.push_back(x);
    else          expB.push_back(x);
  endtask

  task automatic driveBeat(input int sel, input int m0, input int m1, input int e);
    if (sel == 0) begin
      mInA[0] = 8'(m0); mInA[1] = 8'(m1); eInA = 8'(e); inValidA = 1'b1;
    end else begin
      mInB[0] = 8'(m0); mInB[1] = 8'(m1); eInB = 8'(e); inValidB = 1'b1;
    end
  endtask

  task automatic waitAccept(input int sel, input string name);
    int   budget = 0;
    logic taken  = 1'b0;
    while (!taken && budget < 50) begin
      @(negedge clk);
      taken = (sel == 0) ? inReadyA : inReadyB;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: beat not accepted within %0d cycles", name, budget);
    end
  endtask

  task automatic applyStimulus(input int sel, input int m0, input int m1, input int e, input string name);
    driveBeat(sel, m0, m1, e);
    waitAccept(sel, name);
  endtask

  task automatic idle(input int sel);
    if (sel == 0) inValidA = 1'b0;
    else          inValidB = 1'b0;
  endtask

  // Monitors retire one expected block per output handshake.
  always @(negedge clk) begin
    if (!rst && outValidA && outReadyA) begin
      if (expA.size() == 0) begin
        checkOutput("A unexpected output", 1, 0);
      end else begin
        popA = expA.pop_front();
        checkOutput("A m[0]", int'($signed(mOutA[0])), popA.m0);
        checkOutput("A m[1]", int'($signed(mOutA[1])), popA.m1);
        checkOutput("A e",    int'($signed(eOutA)),    popA.e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && outValidB && outReadyB) begin
      if (expB.size() == 0) begin
        checkOutput("B unexpected output", 1, 0);
      end else begin
        popB = expB.pop_front();
        checkOutput("B m[0]", int'($signed(mOutB[0])), popB.m0);
        checkOutput("B m[1]", int'($signed(mOutB[1])), popB.m1);
        checkOutput("B e",    int'($signed(eOutB)),    popB.e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mInA = '0; eInA = '0; inValidA = 1'b0; outReadyA = 1'b1;
    mInB = '0; eInB = '0; inValidB = 1'b0; outReadyB = 1'b1;
    #2;
    checkOutput("reset A valid", int'(outValidA), 0);
    checkOutput("reset A m[0]",  int'(mOutA[0]), 0);
    checkOutput("reset A e",     int'(eOutA), 0);
    checkOutput("reset B valid", int'(outValidB), 0);
    #6 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("A ready after reset", int'(inReadyA), 1);
    checkOutput("B ready after reset", int'(inReadyB), 1);

    // Equal exponents, plus one-cycle latency after the last beat.
    pushExpected(0, 4, -8, 3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, -2, 3, "equal beat");
    checkOutput("A valid before last beat", int'(outValidA), 0);
    applyStimulus(0, 1, -2, 3, "equal last beat");
    checkOutput("A valid after last beat", int'(outValidA), 1);
    idle(0);
    repeat (3) @(posedge clk);
    #1;

    // Rising, falling and large-gap blocks back to back on the depth-2 instance.
    pushExpected(1, 3, 3, 2);
    applyStimulus(1, 8, 8, 0, "rise beat0");
    applyStimulus(1, 1, 1, 2, "rise beat1");
    pushExpected(1, 6, -6, 2);
    applyStimulus(1, 4, -4, 2, "fall beat0");
    applyStimulus(1, 8, -8, 0, "fall beat1");
    pushExpected(1, -1, 0, 20);
    applyStimulus(1, -1, 5, 0, "gap beat0");
    applyStimulus(1, 0, 0, 20, "gap beat1");
    idle(1);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: stalled result must hold while the next block's first beat waits.
    outReadyA = 1'b0;
    pushExpected(0, 8, 12, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2, 3, 1, "bp block1");
    pushExpected(0, 4, 4, 1);
    driveBeat(0, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall in_ready", int'(inReadyA), 0);
      checkOutput("stall valid",    int'(outValidA), 1);
      checkOutput("stall m[0]",     int'($signed(mOutA[0])), 8);
      checkOutput("stall m[1]",     int'($signed(mOutA[1])), 12);
      checkOutput("stall e",        int'($signed(eOutA)), 1);
    end
    @(posedge clk); #1;
    outReadyA = 1'b1;
    waitAccept(0, "bp release beat");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 1, "bp block2");
    idle(0);
    repeat (3) @(posedge clk);
    #1;

    // Mid-block asynchronous reset discards the partial sum and clears the outputs.
    applyStimulus(0, 7, 7, 5, "pre-reset beat0");
    applyStimulus(0, 7, 7, 5, "pre-reset beat1");
    idle(0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async reset valid", int'(outValidA), 0);
    checkOutput("async reset m[0]",  int'(mOutA[0]), 0);
    checkOutput("async reset m[1]",  int'(mOutA[1]), 0);
    checkOutput("async reset e",     int'(eOutA), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    pushExpected(0, 4, 4, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, "post-reset beat");
    idle(0);

    for (int i = 0; i < 20 && (expA.size() != 0 || expB.size() != 0); i++) @(posedge clk);
    #1;
    checkOutput("A scoreboard drained", expA.size(), 0);
    checkOutput("B scoreboard drained", expB.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
